// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver with a one-word valid/ready output
// stage. Deserialises LSB-first frames with optional parity and one or two
// stop bits, and reports frame, parity and overrun status with each word.
module uart_rx_core #(
    parameter int DELAY_FRAMES = 234,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int CNT_W = $clog2(DELAY_FRAMES);
    localparam int HALF  = DELAY_FRAMES / 2;
    localparam int BIT_W = 4;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic                 rx_meta;
    logic                 rxs;
    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic                 perr_r, perr_n;
    logic                 ferr_r, ferr_n;
    logic                 done;
    logic                 done_ferr;
    logic                 tick;

    // Two-flop synchroniser; resets to the idle-high line level so reset
    // release never looks like a start edge unless the pin really is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep both flops sampling the
            // pre-edge values, which is what makes this a two-stage chain.
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    // FSM state and bit-timing registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift_r <= '0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shift_r <= shift_n;
            perr_r  <= perr_n;
            ferr_r  <= ferr_n;
        end
    end

    assign tick = (cnt == CNT_LAST);

    // Next-state logic: bit sampling, shifting, parity/stop evaluation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        bit_cnt_n = bit_cnt;
        shift_n   = shift_r;
        perr_n    = perr_r;
        ferr_n    = ferr_r;
        done      = 1'b0;
        done_ferr = 1'b0;

        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n   = S_START;
                    bit_cnt_n = '0;
                    perr_n    = 1'b0;
                    ferr_n    = 1'b0;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_n = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_n   = '0;
                    shift_n = {rxs, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_n   = '0;
                    state_n = S_STOP;
                    if (PARITY_MODE == 1) perr_n = ^shift_r ^ rxs;
                    else                  perr_n = ~(^shift_r ^ rxs);
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_n = '0;
                    if (!rxs) ferr_n = 1'b1;
                    if (bit_cnt == STOP_LAST) begin
                        done      = 1'b1;
                        done_ferr = ferr_r | ~rxs;
                        bit_cnt_n = '0;
                        // Returning straight to IDLE lets a start bit that
                        // immediately follows the stop bit be caught.
                        state_n   = rxs ? S_IDLE : S_BREAK;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output slot: load a completed word when free, otherwise flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_r;
                    frame_err  <= done_ferr;
                    parity_err <= perr_r;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receiver, the receive-side counterpart to the UART transmitter. It deserialises frames on `uart_rx` and supports configurable data width, parity and stop bits. Each received word is presented on a valid/ready output with frame, parity and overrun status. It sits between the board RX pin and the downstream byte consumer (command parser / FIFO) in the same clock domain as the transmitter.

Parameters:
- DELAY_FRAMES, 234: clk cycles per bit (27 MHz / 115200 baud); must be >= 4.
- DATA_BITS, 8: data bits per frame, range 5..9, sent LSB first.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits checked, 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- uart_rx  in  1  serial input, asynchronous to clk, idle high
- rx_data  out  DATA_BITS  received word, LSB = first data bit
- rx_valid  out  1  rx_data and status flags valid
- rx_ready  in  1  consumer accepts word when rx_valid && rx_ready
- frame_err  out  1  a stop bit of the held word sampled 0; qualified by rx_valid
- parity_err  out  1  parity mismatch on the held word; qualified by rx_valid; always 0 when PARITY_MODE = 0
- overrun_err  out  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset (async assert, sync release): FSM = IDLE; rx_data = 0; rx_valid = 0; frame_err = 0; parity_err = 0; overrun_err = 0; synchroniser flops = 1; counters = 0.
- Input path: 2-flop synchroniser on uart_rx. All decisions use the synchronised signal `rxs`.
- Bit counter width: clog2(DELAY_FRAMES). HALF = DELAY_FRAMES/2 (floor).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - first cycle with rxs = 0 is t0; go to START.
- START:
  - sample at t0 + HALF.
  - rxs = 1 -> false start (glitch); return to IDLE, no output.
  - rxs = 0 -> go to DATA.
- DATA:
  - DATA_BITS samples, each DELAY_FRAMES cycles after the previous sample.
  - shift LSB first.
  - then go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - one sample.
  - even: error if XOR(data, pbit) = 1.
  - odd: error if XOR(data, pbit) = 0.
- STOP:
  - STOP_BITS samples at DELAY_FRAMES spacing.
  - any sample 0 sets the frame error for this frame.
  - on the last stop sample, the frame completes.
  - last stop sample 0 -> go to BREAK; otherwise go to IDLE.
  - IDLE is re-armed on the same cycle, so back-to-back frames with no idle gap are received.
- BREAK: wait until rxs = 1, then go to IDLE. A line held low must not generate further frames.
- Completion (cycle C = last stop sample): on C+1, one of three outcomes.
  - Output slot free (rx_valid = 0, or rx_valid && rx_ready at C): load rx_data, frame_err and parity_err; set rx_valid = 1.
  - Slot occupied and not being accepted: drop the new frame; keep the old data and flags; overrun_err = 1 for exactly one cycle.
- Handshake:
  - rx_valid stays high, and rx_data/flags stay stable, until accepted.
  - Acceptance with no new completion clears rx_valid on the next cycle.
  - Simultaneous accept and completion: the new word replaces the old one, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 1 cycle after the middle of the last stop bit (synchroniser adds 2 cycles relative to the pin).
- Reset mid-frame: frame is abandoned, all outputs are cleared, and after release the receiver waits in IDLE for the next falling edge. If the pin is low at release, that counts as a start edge.
- rx_ready is don't-care while rx_valid = 0.

Test Plan:
- Basic frame: DELAY_FRAMES = 16, 8N1, send 0x41 then hold high, rx_ready = 1 -> rx_valid pulses once, rx_data = 0x41, frame_err = 0, parity_err = 0, overrun_err = 0; rx_valid rises 1 + 2 cycles after the stop-bit midpoint at the pin.
- Parity: PARITY_MODE = 1, send 0x41 with parity bit 0 -> parity_err = 0. Resend with parity bit 1 -> rx_data = 0x41, parity_err = 1. PARITY_MODE = 2 with parity bit 1 -> parity_err = 0.
- Glitch rejection: DELAY_FRAMES = 16, pull uart_rx low for 4 cycles -> no rx_valid. A valid 0xA5 frame afterwards is received correctly.
- Framing/break: send 0x3C with stop bit 0, then hold the line low for 200 cycles -> one word 0x3C with frame_err = 1 and no further frames. After the line goes high, the next 0x12 frame is received cleanly.
- Overrun and back-to-back: rx_ready = 0, send 0x55 then 0xAA with no gap -> rx_data stays 0x55, overrun_err is high for exactly 1 cycle at 0xAA completion. After raising rx_ready, only 0x55 is delivered. Repeat with rx_ready = 1 -> both words are delivered, no overrun.
- Reset mid-frame + config sweep: assert rst during DATA bit 3 -> all outputs 0 immediately, no word emitted. Then run DATA_BITS = 5/7/9 with STOP_BITS = 2 and check random words against the reference model.
